// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment receive path.
//   - SEG_0..SEG_9, SEG_BLANK : active-low patterns, bit0=a .. bit6=g
//   - state_t                 : seg_scan_decoder FSM states
//   - DIGIT_W                 : BCD digit width
package seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        MAC1,
        MAC2,
        MAC3,
        PUBLISH
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational active-low 7-segment pattern -> BCD decoder.
//   seg      : pattern, bit0=a .. bit6=g, active-low
//   legal    : pattern is a digit 0..9 or blank
//   is_blank : pattern is all segments off (decodes as 0)
//   bcd      : decoded digit (0 for blank or illegal)
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0]         seg,
    output logic               legal,
    output logic               is_blank,
    output logic [DIGIT_W-1:0] bcd
);

    always_comb begin
        legal    = 1'b1;
        is_blank = 1'b0;
        bcd      = '0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds a 4-digit decimal number from a multiplexed,
// active-low 7-segment stream (pos 3 first) and publishes it once it has
// been seen in STABLE_FRAMES consecutive identical frames.
//   CLOCK_50    : clock
//   reset       : synchronous, active-high
//   seg_in      : active-low pattern, bit0=a .. bit6=g
//   seg_pos     : digit index, 3 = most significant
//   seg_valid   : seg_in/seg_pos presented; transfer = seg_valid & seg_ready
//   seg_ready   : digit accepted this cycle (IDLE/COLLECT only)
//   value       : last published binary value (0..9999)
//   digits      : last published BCD digits, [15:12] = pos 3
//   value_valid : one-cycle pulse when value/digits update
//   err         : one-cycle pulse on a rejected frame
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_FRAMES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic [1:0]  seg_pos,
    input  logic        seg_valid,
    output logic        seg_ready,
    output logic [13:0] value,
    output logic [15:0] digits,
    output logic        value_valid,
    output logic        err
);

    localparam int             CNT_W = 4;
    localparam logic [CNT_W-1:0] SF  = CNT_W'(STABLE_FRAMES);

    state_t                    state, state_nxt;
    logic [1:0]                exp_pos;
    logic [3:0][DIGIT_W-1:0]   dig;
    logic                      lead_blank;   // every digit taken so far in this frame was blank
    logic [13:0]               acc, acc_step, last_frame;
    logic [CNT_W-1:0]          match_cnt, cnt_nxt;
    logic [DIGIT_W-1:0]        mac_digit;

    logic                      pat_legal, pat_blank;
    logic [DIGIT_W-1:0]        pat_bcd;
    logic                      xfer, digit_ok;
    logic                      start, take, err_nxt;
    logic                      frame_match, pub;

    seg7_to_bcd u_dec (
        .seg      (seg_in),
        .legal    (pat_legal),
        .is_blank (pat_blank),
        .bcd      (pat_bcd)
    );

    assign seg_ready = ~reset & ((state == IDLE) | (state == COLLECT));
    assign xfer      = seg_valid & seg_ready;
    // Blank stands for a leading zero only: fine at pos 3, otherwise only
    // while all higher digits of the frame were blank too.
    assign digit_ok  = pat_legal & (~pat_blank | (seg_pos == 2'd3) | lead_blank);

    // acc*10 + digit as (acc<<3) + (acc<<1); acc <= 999 before each step.
    always_comb begin
        case (state)
            MAC1:    mac_digit = dig[2];
            MAC2:    mac_digit = dig[1];
            default: mac_digit = dig[0];
        endcase
    end
    assign acc_step = {acc[10:0], 3'b000} + {acc[12:0], 1'b0} + 14'(mac_digit);

    // Stability is resolved on the MAC3 -> PUBLISH edge so that value,
    // digits and value_valid all become visible in the PUBLISH cycle.
    always_comb begin
        frame_match = (acc_step == last_frame);
        if (!frame_match)
            cnt_nxt = CNT_W'(1);
        else if (match_cnt == SF)
            cnt_nxt = SF;
        else
            cnt_nxt = match_cnt + CNT_W'(1);
        pub = (cnt_nxt == SF) && !(frame_match && (match_cnt == SF));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        take      = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (digit_ok && seg_pos == 2'd3) begin
                        start     = 1'b1;
                        state_nxt = COLLECT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    if (!digit_ok) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (seg_pos == exp_pos) begin
                        take = 1'b1;
                        if (seg_pos == 2'd0) state_nxt = MAC1;
                    end else if (seg_pos == 2'd3) begin
                        // new frame start: abandon the partial one
                        err_nxt = 1'b1;
                        start   = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            MAC1:    state_nxt = MAC2;
            MAC2:    state_nxt = MAC3;
            MAC3:    state_nxt = PUBLISH;
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            exp_pos     <= 2'd2;
            dig         <= '0;
            lead_blank  <= 1'b0;
            acc         <= '0;
            last_frame  <= '0;
            match_cnt   <= '0;
            value       <= '0;
            digits      <= '0;
            value_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            err         <= err_nxt;
            value_valid <= 1'b0;
            if (start) begin
                dig[3]     <= pat_bcd;
                acc        <= 14'(pat_bcd);
                exp_pos    <= 2'd2;
                lead_blank <= pat_blank;
            end
            if (take) begin
                dig[seg_pos] <= pat_bcd;
                exp_pos      <= exp_pos - 2'd1;
                lead_blank   <= lead_blank & pat_blank;
            end
            if (state == MAC1 || state == MAC2 || state == MAC3)
                acc <= acc_step;
            if (state == MAC3) begin
                last_frame <= acc_step;
                match_cnt  <= cnt_nxt;
                if (pub) begin
                    value       <= acc_step;
                    digits      <= dig;
                    value_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive end of the seven-segment display path: takes a time-multiplexed, active-low 7-segment digit stream (one digit per transfer, most significant first) and rebuilds the 4-digit decimal number it shows.
- Decodes each pattern to BCD, accumulates the frame into a binary value (0..9999) and rejects illegal patterns or out-of-order digits.
- Publishes a value only after it has been seen in STABLE_FRAMES consecutive identical frames.
- Used to check display drivers in loopback and to read external segment buses back into the datapath.

Parameters:
STABLE_FRAMES, 2, consecutive identical valid frames required before publishing (legal range 1..15)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
seg_in  in  7  segment pattern, active-low; bit0=a .. bit6=g
seg_pos  in  2  digit index; 3 = most significant, 0 = least significant
seg_valid  in  1  seg_in/seg_pos are presented this cycle
seg_ready  out  1  block accepts a digit this cycle; transfer = seg_valid & seg_ready
value  out  14  last published binary value
digits  out  16  last published BCD digits, [15:12] = pos3
value_valid  out  1  one-cycle pulse when value/digits update
err  out  1  one-cycle pulse on a rejected frame

Behaviour:
- Interface decision: one clock (CLOCK_50); reset is synchronous and active-high.
- Reset values: value=0, digits=0, value_valid=0, err=0, seg_ready=0 during the reset cycle and 1 in the first cycle after reset. FSM goes to IDLE; match count and last-frame register are cleared.
- Pattern decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blank (1111111) decodes as 0, but only as a leading digit: it is legal only while every higher digit of the frame was also blank. Any other pattern is illegal.
- States: IDLE, COLLECT, MAC1, MAC2, MAC3, PUBLISH. seg_ready=1 only in IDLE and COLLECT.
- IDLE: a transfer with pos=3 stores d3, sets acc=d3 and moves to COLLECT expecting pos 2. A transfer with pos≠3 pulses err and stays in IDLE.
- COLLECT: the expected pos stores the digit and decrements the expectation. When pos 0 is accepted, go to MAC1.
- COLLECT: pos=3 restarts the frame and pulses err for the abandoned frame. Any other unexpected pos pulses err and returns to IDLE.
- An illegal pattern in any transfer pulses err the following cycle and the frame is discarded (back to IDLE).
- MAC1/MAC2/MAC3: acc = acc*10 + d2, then d1, then d0. acc is 14 bits and never exceeds 9999. One step per cycle, implemented as shift-add (x8 + x2), not a multiplier.
- PUBLISH stability rule:
  - If acc == last_frame, match_cnt increments, saturating at STABLE_FRAMES.
  - Otherwise last_frame=acc and match_cnt=1.
  - When match_cnt becomes exactly STABLE_FRAMES in this cycle, value, digits and value_valid update with the pulse in the PUBLISH cycle.
  - Further identical frames do not pulse again.
- Next state is IDLE.
- Latency: last digit accepted in cycle T → PUBLISH (value_valid) at T+4 → seg_ready high at T+5.
- seg_valid while seg_ready=0 is ignored (not an error); the source must hold its data.
- err and value_valid are never high in the same cycle.
- Discarded frames do not modify last_frame or match_cnt.
- Reset mid-frame or mid-MAC abandons all partial state with no pulse.

Decomposition:
- Package seg_pkg: active-low pattern constants SEG_0..SEG_9 and SEG_BLANK, the FSM state enum, and the digit width constant.
- One natural sub-module: seg7_to_bcd, a combinational pattern → {legal, is_blank, bcd[3:0]} decoder. It is the inverse of the team's existing digit-to-segment encoder and is reused by bench scoreboards.

Test Plan:
- STABLE_FRAMES=2: two frames of patterns for 1,2,3,4 (pos 3..0) → no pulse after the first frame; value_valid at T+4 of the second with value=1234, digits=0x1234; a third identical frame gives no pulse.
- Frame blank,blank,blank,7 sent twice → value=7, digits=0x0007. Frame 5,blank,0,0 → err pulse, outputs unchanged.
- Frame 9,9,9,9 twice → value=9999 (14'h270F), no overflow.
- Out-of-order: pos 3,2,0 → err one cycle after the pos-0 transfer, FSM in IDLE. A following clean 0,0,4,2 frame (twice) publishes 42.
- Illegal pattern 0001000 at pos 1 → err pulse, frame dropped, match count unaffected. Subsequent stable frames of 8,8,8,8 publish 8888.
- Hold seg_valid high through MAC1–PUBLISH → seg_ready=0 for exactly 4 cycles, no digit consumed, no err. Reset asserted during MAC2 → no value_valid, and all outputs equal their reset values the next cycle.
